// File: rtl/npu_bcast_pkg.sv
// npu_bcast_pkg: shared broadcast modes, FSM states and default geometry for the broadcast unit and PE array
package npu_bcast_pkg;
  localparam int LANES_DEF = 8;
  localparam int ELEM_W_DEF = 8;
  localparam int DEPTH_DEF = 512;
  localparam int CNT_W_DEF = 32;
  typedef enum logic {BC_WRAP, BC_SCALAR} bcast_mode_e;
  typedef enum logic [1:0] {IDLE, PREP, STREAM} bcast_state_e;
endpackage

// File: rtl/bcast_lane_index_gen.sv
// bcast_lane_index_gen: per-lane cache index registers with job init and add-step-wrap advance
//   clk, rst      clock, async active-high reset
//   init          load start indices (WRAP: j mod n, SCALAR: 0)
//   adv           advance every lane by step, wrapping once at n (step < n guaranteed)
//   mode, n, step job configuration
//   idx           lane j cache index
module bcast_lane_index_gen
  import npu_bcast_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int AW = 9,
  localparam int IW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic adv,
  input  bcast_mode_e mode,
  input  logic [IW-1:0] n,
  input  logic [IW-1:0] step,
  output logic [LANES-1:0][AW-1:0] idx
);
  logic [LANES-1:0][AW-1:0] seed;
  logic [LANES-1:0][IW-1:0] sum, nxt;
  always_comb begin
    seed[0] = '0;
    for (int j = 1; j < LANES; j++)
      seed[j] = (mode == BC_SCALAR || {1'b0, seed[j-1]} + IW'(1) == n) ? '0 : seed[j-1] + AW'(1);
    for (int j = 0; j < LANES; j++) begin
      sum[j] = IW'(idx[j]) + step;
      nxt[j] = sum[j] >= n ? sum[j] - n : sum[j];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) idx <= '0;
    else if (init) idx <= seed;
    else if (adv) for (int j = 0; j < LANES; j++) idx[j] <= AW'(nxt[j]);
endmodule

// File: rtl/broadcast_stream_unit.sv
// broadcast_stream_unit: caches an element vector and streams WRAP/SCALAR broadcast beats under valid/ready
//   wr_valid/wr_ready/wr_addr/wr_data   LANES-element cache write, addresses wrap mod DEPTH
//   cfg_clear/start/abort/mode/num_elem/num_beats   job control, sampled in IDLE
//   out_valid/out_ready/out_data        broadcast beat stream
//   busy, done (1-cycle job end pulse), err (sticky, cleared by start)
module broadcast_stream_unit
  import npu_bcast_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IW = ADDR_W + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES*ELEM_W-1:0] wr_data,
  input  logic cfg_clear,
  input  logic cfg_start,
  input  logic cfg_abort,
  input  logic cfg_mode,
  input  logic [CNT_W-1:0] cfg_num_elem,
  input  logic [CNT_W-1:0] cfg_num_beats,
  output logic out_valid,
  input  logic out_ready,
  output logic [LANES*ELEM_W-1:0] out_data,
  output logic busy,
  output logic done,
  output logic err
);
  bcast_state_e state, state_d;
  bcast_mode_e mode;
  logic [CNT_W-1:0] n, step, beats_left;
  logic [DEPTH-1:0] vld;
  logic [ELEM_W-1:0] cache [DEPTH];
  logic [LANES-1:0][ADDR_W-1:0] idx;
  logic [LANES*ELEM_W-1:0] rd_data;
  logic rd_miss, can_go, bad, go, sub, emit, fin, done_d, wr_fire, clr;
  assign wr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wr_fire = wr_valid && wr_ready;
  assign clr = cfg_clear && state == IDLE && !cfg_abort;
  always_comb begin
    can_go = !out_valid || out_ready;
    bad = cfg_num_elem == '0 || cfg_num_elem > CNT_W'(DEPTH);
    go = state == IDLE && cfg_start && !cfg_abort;
    sub = state == PREP && !cfg_abort && step >= n;
    emit = state == STREAM && !cfg_abort && can_go && beats_left != '0;
    fin = state == STREAM && !cfg_abort && can_go && beats_left == '0;
    done_d = (cfg_abort && state != IDLE) || (go && bad) || fin;
    state_d = cfg_abort ? IDLE :
              (go && !bad) ? PREP :
              (state == PREP && step < n) ? STREAM :
              fin ? IDLE : state;
  end
  // Unwritten entries read as zero and flag the job as erroneous.
  always_comb begin
    rd_data = '0;
    rd_miss = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      rd_data[j*ELEM_W +: ELEM_W] = vld[idx[j]] ? cache[idx[j]] : '0;
      rd_miss = rd_miss | !vld[idx[j]];
    end
  end
  bcast_lane_index_gen #(.LANES(LANES), .AW(ADDR_W)) u_idx (
    .clk(clk),
    .rst(rst),
    .init(state == PREP),
    .adv(emit),
    .mode(mode),
    .n(IW'(n)),
    .step(IW'(step)),
    .idx(idx)
  );
  always_ff @(posedge clk)
    if (wr_fire)
      for (int i = 0; i < LANES; i++) cache[wr_addr + ADDR_W'(i)] <= wr_data[i*ELEM_W +: ELEM_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mode <= BC_WRAP;
      n <= '0;
      step <= '0;
      beats_left <= '0;
      vld <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      done <= done_d;
      if (clr) vld <= '0;
      if (wr_fire) for (int i = 0; i < LANES; i++) vld[wr_addr + ADDR_W'(i)] <= 1'b1;
      if (go) begin
        err <= bad;
        n <= cfg_num_elem;
        mode <= bcast_mode_e'(cfg_mode);
        beats_left <= cfg_num_beats;
        // Step starts at the raw lane advance and is reduced mod N in PREP by repeated subtraction.
        step <= bcast_mode_e'(cfg_mode) == BC_SCALAR ? CNT_W'(1) : CNT_W'(LANES);
      end
      if (sub) step <= step - n;
      if (emit) begin
        out_data <= rd_data;
        out_valid <= 1'b1;
        beats_left <= beats_left - CNT_W'(1);
        if (rd_miss) err <= 1'b1;
      end
      if (fin || cfg_abort) out_valid <= 1'b0;
    end
endmodule
